serializer: RTL

Parallel-to-serial converter that is the upstream counterpart of `deserializer`. It accepts a 16-bit word plus a valid-bit count, then shifts the selected bits out MSB-first, one bit per clock, with a per-bit valid strobe. The serial pair (`ser_data_o`, `ser_data_val_o`) connects directly to `deserializer`'s `data_i` / `data_val_i`. `busy_o` stalls the word source while a transfer is in progress.

---
 rtl/serializer_pkg.sv | 15 +
 rtl/serializer.sv | 90 +++++++++
 2 files changed

// File: rtl/serializer_pkg.sv
// Shared constants and state encoding for the parallel-to-serial converter.
package serializer_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned MOD_W_DEF  = $clog2(DATA_W_DEF);

    // Shortest word the downstream deserializer can frame; lengths below are dropped.
    localparam int unsigned MIN_LEN    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

endpackage

// File: rtl/serializer.sv
// Parallel-to-serial converter: accepts a word plus a bit count and shifts the
// selected bits out MSB-first, one per clock, with a per-bit valid strobe.
module serializer
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(DATA_W);
    localparam logic [MOD_W:0] MIN_L    = (MOD_W+1)'(MIN_LEN);

    state_t            state;
    state_t            state_next;
    logic [DATA_W-1:0] shreg;
    logic [MOD_W:0]    remain;     // bits still to emit after the one on the output
    logic [MOD_W:0]    len;
    logic              len_ok;
    logic              accept;
    logic              last;
    logic              ser_data;
    logic              ser_val;

    // Effective length decode, legality check and next-state selection.
    always_comb begin
        len        = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
        len_ok     = (len >= MIN_L);
        accept     = 1'b0;
        last       = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (data_val_i && len_ok) begin
                    accept     = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (remain == '0) begin
                    last       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus shift register, counter and registered serial outputs.
    // The MSB is loaded straight onto the output at acceptance so the first bit
    // is valid the cycle after the accepting edge.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state    <= IDLE;
            shreg    <= '0;
            remain   <= '0;
            ser_data <= 1'b0;
            ser_val  <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                ser_data <= data_i[DATA_W-1];
                ser_val  <= 1'b1;
                shreg    <= {data_i[DATA_W-2:0], 1'b0};
                remain   <= len - 1'b1;
            end else if (last) begin
                ser_data <= 1'b0;
                ser_val  <= 1'b0;
                shreg    <= '0;
            end else if (state == SHIFT) begin
                ser_data <= shreg[DATA_W-1];
                shreg    <= {shreg[DATA_W-2:0], 1'b0};
                remain   <= remain - 1'b1;
            end
        end
    end

    assign ser_data_o     = ser_data;
    assign ser_data_val_o = ser_val;
    assign busy_o         = ser_val;

endmodule
